issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; SHALL be a power of two and at least 4.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid  in  2  decode slot valid; slot 0 is older.
- dec_uop  in  2 x uop_t  decoded micro-ops from decode.
- dec_ready  out  1  queue can accept two micro-ops this cycle.
- stall_issue  in  1  OR of Stall_Issue_Branch_Pipeline and Stall_Issue_Memory_Pipeline.
- flush  in  1  branch-correction flush.
- iss_b_valid  out  1  branch-pipeline issue register valid.
- iss_b_uop  out  uop_t  micro-op sent to the branch pipeline.
- iss_m_valid  out  1  memory-pipeline issue register valid.
- iss_m_uop  out  uop_t  micro-op sent to the memory pipeline.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
REQ-003 uop_t SHALL hold: pc[31:0], rs1[4:0], rs2[4:0], rd[4:0], rf_we, load_type[2:0], store_type[1:0], branch_en, imm[31:0], alu_op[3:0].

Function
REQ-004 Circular FIFO: head/tail pointers and count; micro-ops SHALL leave in program order.
REQ-005 dec_ready SHALL be (count <= DEPTH-2), computed from registered count only.
REQ-006 Enqueue when dec_ready: dec_valid 01 writes slot 0; 11 writes slot 0 then slot 1; 10 writes slot 1 at tail (compacted); 00 writes nothing.
REQ-007 Class per uop: MEM if load_type!=0 or store_type!=0; BR if branch_en; else ALU.
REQ-008 Candidate A = head (count>=1). Steering: MEM goes to the M lane; BR and ALU go to the B lane.
REQ-009 Candidate C = head+1 (count>=2). C issues in the same cycle only if A issues and both hold:
- lane free: a MEM C needs M free; a BR C needs B free; an ALU C takes whichever lane is free.
- no dependency: NOT (A.rf_we and A.rd!=0 and A.rd in {C.rs1, C.rs2, C.rd}).
REQ-010 C SHALL never issue without A. Two MEM ops or two BR ops SHALL never issue together.
REQ-011 With stall_issue=0, issue registers load the selection each edge. An unused lane gets valid=0. Dequeue count = number issued (0, 1 or 2).
REQ-012 With stall_issue=1, issue registers, head and issued entries SHALL hold. Enqueue continues per REQ-005/006.
REQ-013 Same-cycle enqueue and dequeue: next count = count + enq - deq. Pointers wrap modulo DEPTH.
REQ-014 flush=1 has priority over stall and enqueue. At the next edge: count=0, head=tail=0, iss_b_valid=iss_m_valid=0. That cycle's dec inputs are dropped.
REQ-015 Latency: a uop enqueued at edge N SHALL appear on the iss_* outputs no earlier than after edge N+1. There is no decode-to-issue bypass.
REQ-016 occupancy SHALL equal registered count.

Reset
REQ-017 While rst_n=0, asynchronously: count, head, tail = 0; iss_b_valid = iss_m_valid = 0; iss_b_uop = iss_m_uop = 0. dec_ready is therefore 1.
REQ-018 Reset asserted mid-operation SHALL discard all queued entries. No partial state is retained.

Structure
REQ-019 Package superscalar_pkg SHALL hold uop_t, the class enum {ALU, BR, MEM}, DEPTH_DEFAULT and a classify function.
REQ-020 One sub-module, issue_pair_check, SHALL compute combinationally: lane steering for A and C, the dependency test, and the issue count.

Verification
REQ-021 Reset: with count=3, pulse rst_n low -> occupancy=0, both valids 0, dec_ready=1 in the same cycle.
REQ-022 Dual issue: enqueue {add x1,x2,x3 ; lw x4,0(x5)} -> two edges later iss_b_valid=1 (add), iss_m_valid=1 (lw), occupancy=0.
REQ-023 Dependency:
- {addi x3,x0,1 ; sub x4,x3,x5} -> addi alone on B, then sub on B the next cycle.
- {addi x0,x0,1 ; sub x4,x0,x5} -> both issue together.
REQ-024 Structural: {lw x1 ; sw x2} -> lw on M with iss_b_valid=0, then sw on M the next cycle.
REQ-025 Stall: fill to 4 entries, hold stall_issue=1 for 3 cycles -> outputs stable, dec_ready=0, occupancy=4. Release -> drains in program order.
REQ-026 Flush: count=3 with stall_issue=1, assert flush together with dec_valid=11 -> next cycle occupancy=0, both valids 0, nothing enqueued.

Source files
------------

// File: rtl/superscalar_pkg.sv
// Shared types for the dual-issue front end: micro-op payload, issue class and classifier.
package superscalar_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_we;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic        branch_en;
    logic [31:0] imm;
    logic [3:0]  alu_op;
  } uop_t;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    BR  = 2'd1,
    MEM = 2'd2
  } uop_class_t;

  // Memory wins over branch so a malformed load/branch combo still goes to the M lane.
  function automatic uop_class_t classify(input logic [2:0] load_type,
                                          input logic [1:0] store_type,
                                          input logic       branch_en);
    if ((load_type != 3'd0) || (store_type != 2'd0)) return MEM;
    if (branch_en) return BR;
    return ALU;
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Lane steering, hazard test and issue count for the two oldest queue entries.
module issue_pair_check
  import superscalar_pkg::*;
(
  input  logic       a_valid,
  input  uop_class_t a_cls,
  input  logic [4:0] a_rd,
  input  logic       a_we,
  input  logic       c_valid,
  input  uop_class_t c_cls,
  input  logic [4:0] c_rs1,
  input  logic [4:0] c_rs2,
  input  logic [4:0] c_rd,
  output logic       a_to_m_c,
  output logic       c_issue_c,
  output logic       c_to_m_c,
  output logic [1:0] n_issue_c
);

  logic dep;
  logic lane_ok;

  always_comb begin
    a_to_m_c = (a_cls == MEM);
    dep = a_we && (a_rd != 5'd0) &&
          ((a_rd == c_rs1) || (a_rd == c_rs2) || (a_rd == c_rd));
    // C can only use the lane A left free.
    unique case (c_cls)
      MEM:     lane_ok = !a_to_m_c;
      BR:      lane_ok = a_to_m_c;
      default: lane_ok = 1'b1;
    endcase
    c_to_m_c  = !a_to_m_c;
    c_issue_c = a_valid && c_valid && lane_ok && !dep;
    n_issue_c = a_valid ? (c_issue_c ? 2'd2 : 2'd1) : 2'd0;
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: two-wide enqueue from decode, up to two issues per cycle into the B and M lanes.
module issue_queue
  import superscalar_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               dec_valid,
  input  uop_t [1:0]               dec_uop,
  output logic                     dec_ready,
  input  logic                     stall_issue,
  input  logic                     flush,
  output logic                     iss_b_valid,
  output uop_t                     iss_b_uop,
  output logic                     iss_m_valid,
  output uop_t                     iss_m_uop,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  uop_t          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  uop_t          a_uop;
  uop_t          c_uop;
  logic          a_valid;
  logic          c_valid;
  logic          a_to_m;
  logic          c_issue;
  logic          c_to_m;
  logic [1:0]    n_issue;

  logic          wr0_en;
  logic          wr1_en;
  uop_t          wr0_data;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;

  logic          b_sel_valid;
  logic          m_sel_valid;
  uop_t          b_sel_uop;
  uop_t          m_sel_uop;

  assign dec_ready = (count <= CW'(DEPTH - 2));
  assign occupancy = count;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign a_uop   = mem[head];
  assign c_uop   = mem[head_p1];
  assign a_valid = (count != '0);
  assign c_valid = (count >= CW'(2));

  issue_pair_check u_pair (
    .a_valid   (a_valid),
    .a_cls     (classify(a_uop.load_type, a_uop.store_type, a_uop.branch_en)),
    .a_rd      (a_uop.rd),
    .a_we      (a_uop.rf_we),
    .c_valid   (c_valid),
    .c_cls     (classify(c_uop.load_type, c_uop.store_type, c_uop.branch_en)),
    .c_rs1     (c_uop.rs1),
    .c_rs2     (c_uop.rs2),
    .c_rd      (c_uop.rd),
    .a_to_m_c  (a_to_m),
    .c_issue_c (c_issue),
    .c_to_m_c  (c_to_m),
    .n_issue_c (n_issue)
  );

  // Enqueue compaction: a lone slot-1 uop still lands at tail.
  always_comb begin
    wr0_en   = dec_ready && !flush && (dec_valid != 2'b00);
    wr1_en   = dec_ready && !flush && (dec_valid == 2'b11);
    wr0_data = dec_valid[0] ? dec_uop[0] : dec_uop[1];
    enq_n    = 2'(wr0_en) + 2'(wr1_en);
    deq_n    = stall_issue ? 2'd0 : n_issue;
  end

  always_comb begin
    b_sel_valid = (a_valid && !a_to_m) || (c_issue && !c_to_m);
    m_sel_valid = (a_valid && a_to_m) || (c_issue && c_to_m);
    b_sel_uop   = (a_valid && !a_to_m) ? a_uop : c_uop;
    m_sel_uop   = (a_valid && a_to_m) ? a_uop : c_uop;
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail] <= wr0_data;
    if (wr1_en) mem[tail_p1] <= dec_uop[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      iss_b_valid <= 1'b0;
      iss_m_valid <= 1'b0;
      iss_b_uop   <= '0;
      iss_m_uop   <= '0;
    end else if (flush) begin
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      iss_b_valid <= 1'b0;
      iss_m_valid <= 1'b0;
    end else begin
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
      if (!stall_issue) begin
        head        <= head + PW'(n_issue);
        iss_b_valid <= b_sel_valid;
        iss_m_valid <= m_sel_valid;
        iss_b_uop   <= b_sel_uop;
        iss_m_uop   <= m_sel_uop;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, dual issue, hazards, stall, flush and compaction.
module tb_issue_queue;
  import superscalar_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] dec_valid;
  uop_t [1:0] dec_uop;
  logic       dec_ready;
  logic       stall_issue;
  logic       flush;
  logic       iss_b_valid;
  uop_t       iss_b_uop;
  logic       iss_m_valid;
  uop_t       iss_m_uop;
  logic [2:0] occupancy;

  int checks;
  int failures;

  issue_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_uop     (dec_uop),
    .dec_ready   (dec_ready),
    .stall_issue (stall_issue),
    .flush       (flush),
    .iss_b_valid (iss_b_valid),
    .iss_b_uop   (iss_b_uop),
    .iss_m_valid (iss_m_valid),
    .iss_m_uop   (iss_m_uop),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic uop_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic we, input logic [2:0] lt,
                              input logic [1:0] st, input logic br);
    uop_t u;
    u = '0;
    u.pc = pc; u.rs1 = rs1; u.rs2 = rs2; u.rd = rd; u.rf_we = we;
    u.load_type = lt; u.store_type = st; u.branch_en = br;
    u.imm = 32'd1; u.alu_op = 4'd0;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [1:0] v, input uop_t u0, input uop_t u1);
    dec_valid  = v;
    dec_uop[0] = u0;
    dec_uop[1] = u1;
    tick();
    dec_valid  = 2'b00;
  endtask

  task automatic chk_lanes(input string tag, input logic bv, input logic [31:0] bpc,
                           input logic mv, input logic [31:0] mpc, input int occ);
    chk({tag, "_bv"}, 32'(iss_b_valid), 32'(bv));
    if (bv) chk({tag, "_bpc"}, iss_b_uop.pc, bpc);
    chk({tag, "_mv"}, 32'(iss_m_valid), 32'(mv));
    if (mv) chk({tag, "_mpc"}, iss_m_uop.pc, mpc);
    chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    uop_t nop;
    checks = 0;
    failures = 0;
    nop = '0;
    rst_n = 1'b0;
    dec_valid = 2'b00;
    dec_uop[0] = '0;
    dec_uop[1] = '0;
    stall_issue = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_lanes("rst", 1'b0, 0, 1'b0, 0, 0);
    chk("rst_rdy", 32'(dec_ready), 32'd1);

    // add x1,x2,x3 ; lw x4,0(x5): dual issue two edges after enqueue
    enq(2'b11, mk(32'h100, 5'd2, 5'd3, 5'd1, 1'b1, 3'd0, 2'd0, 1'b0),
               mk(32'h104, 5'd5, 5'd0, 5'd4, 1'b1, 3'd2, 2'd0, 1'b0));
    chk_lanes("dual_lat", 1'b0, 0, 1'b0, 0, 2);
    tick();
    chk_lanes("dual", 1'b1, 32'h100, 1'b1, 32'h104, 0);
    tick();
    chk_lanes("dual_idle", 1'b0, 0, 1'b0, 0, 0);

    // addi x3,x0,1 ; sub x4,x3,x5: RAW splits them
    enq(2'b11, mk(32'h200, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 2'd0, 1'b0),
               mk(32'h204, 5'd3, 5'd5, 5'd4, 1'b1, 3'd0, 2'd0, 1'b0));
    tick();
    chk_lanes("dep_a", 1'b1, 32'h200, 1'b0, 0, 1);
    tick();
    chk_lanes("dep_c", 1'b1, 32'h204, 1'b0, 0, 0);

    // addi x0,x0,1 ; sub x4,x0,x5: x0 never creates a hazard, ALU C takes M
    enq(2'b11, mk(32'h300, 5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 2'd0, 1'b0),
               mk(32'h304, 5'd0, 5'd5, 5'd4, 1'b1, 3'd0, 2'd0, 1'b0));
    tick();
    chk_lanes("x0", 1'b1, 32'h300, 1'b1, 32'h304, 0);

    // lw x1 ; sw x2: both need M
    enq(2'b11, mk(32'h400, 5'd6, 5'd0, 5'd1, 1'b1, 3'd2, 2'd0, 1'b0),
               mk(32'h404, 5'd6, 5'd2, 5'd0, 1'b0, 3'd0, 2'd2, 1'b0));
    tick();
    chk_lanes("struct_a", 1'b0, 0, 1'b1, 32'h400, 1);
    tick();
    chk_lanes("struct_c", 1'b0, 0, 1'b1, 32'h404, 0);

    // slot 1 only: compacted into tail
    enq(2'b10, nop, mk(32'h500, 5'd1, 5'd2, 5'd7, 1'b1, 3'd0, 2'd0, 1'b0));
    chk("cmp_occ", 32'(occupancy), 32'd1);
    tick();
    chk_lanes("cmp", 1'b1, 32'h500, 1'b0, 0, 0);

    // lw then beq: MEM on M, BR C on free B lane
    enq(2'b11, mk(32'h600, 5'd6, 5'd0, 5'd8, 1'b1, 3'd1, 2'd0, 1'b0),
               mk(32'h604, 5'd1, 5'd2, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1));
    tick();
    chk_lanes("mem_br", 1'b1, 32'h604, 1'b1, 32'h600, 0);

    // Stall: park an add in B, fill four entries behind it
    enq(2'b01, mk(32'h700, 5'd1, 5'd2, 5'd9, 1'b1, 3'd0, 2'd0, 1'b0), nop);
    tick();
    chk_lanes("pre_stall", 1'b1, 32'h700, 1'b0, 0, 0);
    stall_issue = 1'b1;
    enq(2'b11, mk(32'h710, 5'd6, 5'd0, 5'd10, 1'b1, 3'd2, 2'd0, 1'b0),
               mk(32'h714, 5'd6, 5'd2, 5'd0, 1'b0, 3'd0, 2'd1, 1'b0));
    enq(2'b11, mk(32'h718, 5'd6, 5'd0, 5'd11, 1'b1, 3'd2, 2'd0, 1'b0),
               mk(32'h71c, 5'd6, 5'd2, 5'd0, 1'b0, 3'd0, 2'd1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      dec_valid = 2'b11;
      dec_uop[0] = mk(32'hbad0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b0);
      dec_uop[1] = dec_uop[0];
      tick();
      chk_lanes("stall", 1'b1, 32'h700, 1'b0, 0, 4);
      chk("stall_rdy", 32'(dec_ready), 32'd0);
    end
    dec_valid = 2'b00;
    stall_issue = 1'b0;
    tick();
    chk_lanes("drain0", 1'b0, 0, 1'b1, 32'h710, 3);
    chk("drain0_rdy", 32'(dec_ready), 32'd0);
    tick();
    chk_lanes("drain1", 1'b0, 0, 1'b1, 32'h714, 2);
    chk("drain1_rdy", 32'(dec_ready), 32'd1);
    tick();
    chk_lanes("drain2", 1'b0, 0, 1'b1, 32'h718, 1);
    tick();
    chk_lanes("drain3", 1'b0, 0, 1'b1, 32'h71c, 0);

    // Flush beats stall and enqueue
    stall_issue = 1'b1;
    enq(2'b11, mk(32'h800, 5'd6, 5'd0, 5'd1, 1'b1, 3'd2, 2'd0, 1'b0),
               mk(32'h804, 5'd6, 5'd2, 5'd0, 1'b0, 3'd0, 2'd1, 1'b0));
    enq(2'b01, mk(32'h808, 5'd6, 5'd0, 5'd2, 1'b1, 3'd2, 2'd0, 1'b0), nop);
    chk_lanes("pre_flush", 1'b0, 0, 1'b1, 32'h71c, 3);
    flush = 1'b1;
    enq(2'b11, mk(32'h900, 5'd1, 5'd1, 5'd1, 1'b1, 3'd0, 2'd0, 1'b0),
               mk(32'h904, 5'd1, 5'd1, 5'd1, 1'b1, 3'd0, 2'd0, 1'b0));
    chk_lanes("flush", 1'b0, 0, 1'b0, 0, 0);
    chk("flush_rdy", 32'(dec_ready), 32'd1);
    flush = 1'b0;
    stall_issue = 1'b0;
    tick();
    chk_lanes("post_flush", 1'b0, 0, 1'b0, 0, 0);

    // Asynchronous reset with three entries queued
    stall_issue = 1'b1;
    enq(2'b11, mk(32'ha00, 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 2'd0, 1'b0),
               mk(32'ha04, 5'd1, 5'd2, 5'd4, 1'b1, 3'd0, 2'd0, 1'b0));
    enq(2'b01, mk(32'ha08, 5'd1, 5'd2, 5'd5, 1'b1, 3'd0, 2'd0, 1'b0), nop);
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lanes("arst", 1'b0, 0, 1'b0, 0, 0);
    chk("arst_rdy", 32'(dec_ready), 32'd1);
    chk("arst_buop", iss_b_uop.pc, 32'd0);
    tick();
    rst_n = 1'b1;
    stall_issue = 1'b0;
    tick();
    chk_lanes("post_rst", 1'b0, 0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
